// File: rtl/cpu_hang_monitor.sv
// Program-counter progress monitor: counts consecutive qualified fetches that
// revisit a small window of recent PCs and flags a hang when a limit is reached.
module cpu_hang_monitor #(
  parameter int PC_W     = 16,
  parameter int CNT_W    = 8,
  parameter int HIST     = 2,
  parameter int USE_SYNC = 1
) (
  input  logic             phi1,
  input  logic             rst_b,
  input  logic             en,
  input  logic             clr,
  input  logic [PC_W-1:0]  pc,
  input  logic             sync,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] idle_cnt,
  output logic             hang,
  output logic [PC_W-1:0]  hang_pc,
  output logic             hang_pulse
);

  logic [PC_W-1:0] hist [HIST];
  logic [HIST-1:0] valid;

  logic           q;
  logic           match;
  logic           hit;
  logic           miss;
  logic           set_hang;
  logic [CNT_W:0] cnt_inc;

  assign q = en & ((USE_SYNC != 0) ? sync : 1'b1);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < HIST; i++) begin
      if (valid[i] && (hist[i] == pc)) match = 1'b1;
    end
  end

  assign hit  = q & match;
  assign miss = q & ~match;

  // One extra bit so a count at all-ones cannot alias to a small limit.
  assign cnt_inc  = {1'b0, idle_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign set_hang = hit & (limit != '0) & (cnt_inc == {1'b0, limit}) & ~hang;

  always_ff @(posedge phi1 or negedge rst_b) begin
    if (!rst_b) begin
      idle_cnt   <= '0;
      hang       <= 1'b0;
      hang_pc    <= '0;
      hang_pulse <= 1'b0;
      valid      <= '0;
      for (int i = 0; i < HIST; i++) hist[i] <= '0;
    end else if (clr) begin
      idle_cnt   <= '0;
      hang       <= 1'b0;
      hang_pc    <= '0;
      hang_pulse <= 1'b0;
      valid      <= '0;
    end else begin
      hang_pulse <= set_hang;
      if (set_hang) begin
        hang    <= 1'b1;
        hang_pc <= pc;
      end
      if (hit) begin
        if (!(&idle_cnt)) idle_cnt <= cnt_inc[CNT_W-1:0];
      end else if (miss) begin
        idle_cnt <= '0;
        for (int i = HIST-1; i > 0; i--) begin
          hist[i]  <= hist[i-1];
          valid[i] <= valid[i-1];
        end
        hist[0]  <= pc;
        valid[0] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_hang_monitor.sv
// Scoreboard bench for cpu_hang_monitor: four parameterisations share one
// stimulus bus; a behavioural model predicts outputs of the selected instance.
module tb_cpu_hang_monitor;

  logic        phi1 = 1'b0;
  logic        rst_b, en, clr, sync;
  logic [15:0] pc;
  logic [7:0]  limit;

  logic [7:0]  idle0, idle1, idle3;
  logic [3:0]  idle2;
  logic [15:0] hpc0, hpc1, hpc2, hpc3;
  logic [3:0]  hang_v, pulse_v;

  logic [7:0]  o_idle;
  logic        o_hang, o_pulse;
  logic [15:0] o_hpc;
  int          sel;

  always #5 phi1 = ~phi1;

  cpu_hang_monitor #(.PC_W(16), .CNT_W(8), .HIST(1), .USE_SYNC(0)) u_a (
    .phi1(phi1), .rst_b(rst_b), .en(en), .clr(clr), .pc(pc), .sync(sync), .limit(limit),
    .idle_cnt(idle0), .hang(hang_v[0]), .hang_pc(hpc0), .hang_pulse(pulse_v[0]));
  cpu_hang_monitor #(.PC_W(16), .CNT_W(8), .HIST(2), .USE_SYNC(1)) u_b (
    .phi1(phi1), .rst_b(rst_b), .en(en), .clr(clr), .pc(pc), .sync(sync), .limit(limit),
    .idle_cnt(idle1), .hang(hang_v[1]), .hang_pc(hpc1), .hang_pulse(pulse_v[1]));
  cpu_hang_monitor #(.PC_W(16), .CNT_W(4), .HIST(2), .USE_SYNC(0)) u_c (
    .phi1(phi1), .rst_b(rst_b), .en(en), .clr(clr), .pc(pc), .sync(sync), .limit(limit[3:0]),
    .idle_cnt(idle2), .hang(hang_v[2]), .hang_pc(hpc2), .hang_pulse(pulse_v[2]));
  cpu_hang_monitor #(.PC_W(16), .CNT_W(8), .HIST(4), .USE_SYNC(0)) u_d (
    .phi1(phi1), .rst_b(rst_b), .en(en), .clr(clr), .pc(pc), .sync(sync), .limit(limit),
    .idle_cnt(idle3), .hang(hang_v[3]), .hang_pc(hpc3), .hang_pulse(pulse_v[3]));

  always_comb begin
    case (sel)
      0:       begin o_idle = idle0;         o_hpc = hpc0; end
      1:       begin o_idle = idle1;         o_hpc = hpc1; end
      2:       begin o_idle = {4'h0, idle2}; o_hpc = hpc2; end
      default: begin o_idle = idle3;         o_hpc = hpc3; end
    endcase
    o_hang  = hang_v[sel[1:0]];
    o_pulse = pulse_v[sel[1:0]];
  end

  typedef struct packed {
    logic [7:0]  idle;
    logic        hang;
    logic [15:0] hpc;
    logic        pulse;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // behavioural model state
  int        m_n, m_max;
  bit        m_us;
  int        m_idle;
  bit [15:0] m_h [8];
  bit        m_v [8];
  bit        m_hang, m_pulse;
  bit [15:0] m_hpc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 0; m_hang = 0; m_hpc = 0; m_pulse = 0;
    for (int i = 0; i < 8; i++) m_v[i] = 0;
  endtask

  task automatic model_config(input int n, input int mx, input bit us);
    m_n = n; m_max = mx; m_us = us;
  endtask

  task automatic model_step(output exp_t e);
    bit q, hitv, setc;
    int lim;
    q   = en && (m_us ? sync : 1'b1);
    lim = int'(limit) & m_max;
    if (clr) begin
      model_reset();
    end else if (!q) begin
      m_pulse = 0;
    end else begin
      hitv = 0;
      for (int i = 0; i < m_n; i++) if (m_v[i] && m_h[i] == pc) hitv = 1;
      if (hitv) begin
        setc = (lim != 0) && (m_idle + 1 == lim) && !m_hang;
        if (setc) begin m_hang = 1; m_hpc = pc; end
        m_pulse = setc;
        if (m_idle < m_max) m_idle++;
      end else begin
        m_idle = 0; m_pulse = 0;
        for (int i = 7; i > 0; i--) begin m_h[i] = m_h[i-1]; m_v[i] = m_v[i-1]; end
        m_h[0] = pc; m_v[0] = 1;
      end
    end
    e.idle = 8'(m_idle); e.hang = m_hang; e.hpc = m_hpc; e.pulse = m_pulse;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step(e);
    sb.push_back(e);
    @(posedge phi1);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, " sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_val({tag, " idle_cnt"},   o_idle,  e.idle);
      check_val({tag, " hang"},       o_hang,  e.hang);
      check_val({tag, " hang_pc"},    o_hpc,   e.hpc);
      check_val({tag, " hang_pulse"}, o_pulse, e.pulse);
    end
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    tick(tag);
    clr = 1'b0;
  endtask

  int exp_b [5] = '{0, 0, 1, 2, 3};
  int nq, max_idle;

  initial begin
    rst_b = 1'b0; en = 1'b0; clr = 1'b0; sync = 1'b1; pc = 16'h0; limit = 8'h0;
    sel = 0;
    model_config(1, 255, 0);
    model_reset();
    #12 rst_b = 1'b1;
    @(posedge phi1); #1;

    // build up some state, then reset asynchronously mid-cycle
    en = 1'b1; pc = 16'h1234; limit = 8'd2;
    for (int k = 0; k < 4; k++) tick("pre");
    #2 rst_b = 1'b0;
    #1;
    check_val("rst idle_cnt", o_idle, 0);
    check_val("rst hang", o_hang, 0);
    check_val("rst hang_pc", o_hpc, 0);
    check_val("rst hang_pulse", o_pulse, 0);
    model_reset();
    #1 rst_b = 1'b1;

    // stationary PC, HIST=1
    limit = 8'd4; pc = 16'hF000; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick("stat");
      if (k == 4) check_val("stat early hang", o_hang, 0);
    end
    check_val("stat hang", o_hang, 1);
    check_val("stat hang_pc", o_hpc, 16'hF000);
    check_val("stat idle_cnt", o_idle, 4);
    check_val("stat pulse", o_pulse, 1);
    en = 1'b0;
    tick("stat en0");
    check_val("stat pulse drop", o_pulse, 0);
    check_val("stat hang held", o_hang, 1);
    en = 1'b1;

    // two-PC loop, HIST=2 with sync
    sel = 1; model_config(2, 255, 1);
    do_clr("loop clr");
    limit = 8'd3; sync = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = (k % 2 == 0) ? 16'hF010 : 16'hF012;
      tick("loop");
      check_val($sformatf("loop idle s%0d", k + 1), o_idle, exp_b[k]);
    end
    check_val("loop hang", o_hang, 1);
    check_val("loop hang_pc", o_hpc, 16'hF010);

    // stickiness under distinct PCs
    for (int k = 0; k < 4; k++) begin
      pc = 16'h2000 + 16'(k);
      tick("sticky");
    end
    check_val("sticky hang", o_hang, 1);
    check_val("sticky hang_pc", o_hpc, 16'hF010);

    // clr beats a qualified hit on 2003
    clr = 1'b1; pc = 16'h2003;
    tick("clrhit");
    clr = 1'b0;
    check_val("clrhit idle", o_idle, 0);
    check_val("clrhit hang", o_hang, 0);
    tick("clrhit repeat");
    check_val("clrhit repeat miss", o_idle, 0);
    tick("clrhit again");
    check_val("clrhit again hit", o_idle, 1);

    // sync every 3rd cycle, en gated off for a stretch
    do_clr("sync clr");
    limit = 8'd0; pc = 16'h3000; nq = 0;
    for (int k = 0; k < 30; k++) begin
      sync = (k % 3 == 0);
      en   = !(k >= 12 && k < 21);
      if (sync && en) nq++;
      tick("sync");
    end
    check_val("sync final idle", o_idle, nq - 1);
    en = 1'b1; sync = 1'b1;

    // saturation with detection disabled, CNT_W=4
    sel = 2; model_config(2, 15, 0);
    do_clr("sat clr");
    limit = 8'd0; pc = 16'h4000;
    for (int k = 0; k < 40; k++) tick("sat");
    check_val("sat idle", o_idle, 15);
    check_val("sat hang", o_hang, 0);
    limit = 8'd3;
    for (int k = 0; k < 3; k++) tick("lowlim");
    check_val("lowlim hang", o_hang, 0);

    // straight-line code, HIST=4
    sel = 3; model_config(4, 255, 0);
    do_clr("line clr");
    limit = 8'd1; max_idle = 0;
    for (int k = 0; k < 200; k++) begin
      pc = 16'h5000 + 16'(k);
      tick("line");
      if (int'(o_idle) > max_idle) max_idle = int'(o_idle);
    end
    check_val("line max idle", max_idle, 0);
    check_val("line hang", o_hang, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_hang_monitor.md
# cpu_hang_monitor

Synthesizable, parametrised monitor for CPU program-counter progress. It watches the core's PC and opcode-fetch strobe and counts consecutive qualified fetches that revisit a small window of recently seen PCs, so that short self-loops such as `JMP *` or `BNE *` are caught. When the count reaches a programmable limit, it raises a sticky hang flag and captures the offending PC. It sits beside the 6502 core, clocked by the core's phase-1 clock, and feeds simulation end-of-test logic and on-chip debug status.

## Interface
Parameters:
- PC_W, 16, width of the monitored program counter.
- CNT_W, 8, width of the idle counter and of the limit.
- HIST, 2, number of PC history entries (legal range 1..8). HIST=1 detects only an exactly stationary PC.
- USE_SYNC, 1, selects how samples are qualified. 1: only cycles with sync=1 are samples. 0: every enabled cycle is a sample.

Ports:
- phi1  in  1  clock. All state updates occur on its rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- en  in  1  monitor enable. When en=0, all state holds.
- clr  in  1  synchronous clear of count, history, hang flag and captured PC.
- pc  in  PC_W  current program counter.
- sync  in  1  opcode-fetch strobe from the core.
- limit  in  CNT_W  hang threshold. A value of 0 disables hang detection.
- idle_cnt  out  CNT_W  current consecutive-hit count (registered).
- hang  out  1  sticky hang flag (registered).
- hang_pc  out  PC_W  PC of the sample that raised hang (registered).
- hang_pulse  out  1  one-cycle strobe, high on the cycle hang first sets.

## Operation
- Qualified sample: q = en & (USE_SYNC ? sync : 1).
- History: HIST entries, each holding a PC_W value and a valid bit. All entries are invalid after reset or clr.
- hit = q & (pc equals some valid history entry). The compare is combinational and runs in parallel across all entries.
- On a qualified miss:
  - idle_cnt <= 0.
  - Push pc into entry 0. Entries shift 0→1→…→HIST-1, and the oldest entry is dropped.
  - The valid bits shift in the same way, with valid=1 entering at entry 0.
- On a qualified hit:
  - History is unchanged.
  - idle_cnt saturating-increments. At all-ones it holds and never wraps.
- Hang set condition: hit & (limit≠0) & (idle_cnt+1 == limit) & ~hang. The compare uses CNT_W+1-bit arithmetic. When the condition is true:
  - hang <= 1.
  - hang_pc <= pc.
  - hang_pulse <= 1 for exactly one cycle.
- hang is sticky. Further hits, misses, limit changes and en=0 do not clear it. Only clr or rst_b clear hang.
- Once hang=1, hang_pc is frozen. Counting and history updates continue normally.
- Changing limit below the current idle_cnt does not fire hang. The equality test is missed and hang stays 0 until the count is next reset by a miss and climbs again.
- clr=1:
  - idle_cnt, hang, hang_pc and hang_pulse go to 0, and all valid bits go to 0.
  - clr takes priority over a qualified sample in the same cycle; that sample is discarded.
- en=0 (and clr=0): every register holds its value, except hang_pulse, which goes to 0.

## Timing
- Reset (rst_b=0, asynchronous): idle_cnt=0, hang=0, hang_pc=0, hang_pulse=0, all history invalid. Registers take these values immediately; no clock edge is required.
- Release of rst_b: the first rising edge of phi1 after release may process a sample.
- All outputs are registered. An event sampled at edge k is visible after edge k.
- Latency for a constant pc with q=1 on every cycle:
  - The first sample is a miss, because history is empty.
  - Samples 2..N are hits. hang asserts after sample limit+1.
- Loop detection: a loop of L≤HIST distinct PCs produces L misses, then continuous hits. hang asserts after L+limit samples.
- Straight-line code, with all PCs distinct over any window of HIST+1 samples: idle_cnt stays 0.
- hang_pulse is high only on the single cycle following the setting edge, even if en is deasserted immediately afterwards.

## Test plan
- Reset and stationary PC:
  - Stimulus: assert rst_b low mid-cycle. Expect all outputs 0 immediately, with no phi1 edge.
  - Stimulus: release rst_b; HIST=1, USE_SYNC=0, limit=4, pc=16'hF000 constant.
  - Expected: hang rises after the 5th edge, hang_pc=16'hF000, hang_pulse high for exactly 1 cycle, idle_cnt=4.
- Two-PC loop:
  - Stimulus: HIST=2, USE_SYNC=1, limit=3, pc alternates F010/F012 with sync=1 on every sample.
  - Expected: idle_cnt reads 0,0,1,2,3. hang sets on the 5th sample with hang_pc=16'hF010.
- Sync qualification and enable:
  - Stimulus: pulse sync every 3rd cycle and hold en=0 for a stretch of cycles.
  - Expected: idle_cnt changes only on sync cycles with en=1, and holds through the en=0 window.
- Saturation and disable:
  - Stimulus: CNT_W=4, limit=0, constant pc for 40 samples.
  - Expected: idle_cnt saturates at 15, and hang never sets.
- Clear priority and stickiness:
  - Stimulus: after hang has set, apply distinct PCs.
  - Expected: hang stays 1 and hang_pc is unchanged.
  - Stimulus: assert clr in the same cycle as a qualified hit.
  - Expected: next-cycle idle_cnt=0 and hang=0, and the following repeat of that PC is a miss.
- Straight-line code:
  - Stimulus: HIST=4, pc incrementing by 1 for 200 samples.
  - Expected: idle_cnt stays 0 throughout, and hang stays 0.
